// File: rtl/morse_pkg.sv
// ----------------------------------------------------------------------------
// morse_pkg
//  Shared definitions for the Morse decoder: slot codes, FSM state encoding,
//  the default code for an undecodable pattern, and the pattern-to-ASCII
//  table used by the symbol LUT.
//  Table order is A..Z followed by 0..9, so the ASCII code of an entry can be
//  derived from its index (see morse_ascii).
// ----------------------------------------------------------------------------
package morse_pkg;

   localparam logic [1:0] SYM_NONE = 2'b00;
   localparam logic [1:0] SYM_DOT  = 2'b01;
   localparam logic [1:0] SYM_DASH = 2'b10;

   localparam logic [7:0] INVALID_CHAR_DEFAULT = 8'h3F;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOOKUP = 2'd1,
      ST_PUSH   = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   localparam int NUM_CODES = 36;

   // First symbol in [9:8], last in [1:0]; 01 = dot, 10 = dash, 00 = none.
   localparam logic [9:0] MORSE_PAT [NUM_CODES] = '{
      10'b0110000000,  // A .-
      10'b1001010100,  // B -...
      10'b1001100100,  // C -.-.
      10'b1001010000,  // D -..
      10'b0100000000,  // E .
      10'b0101100100,  // F ..-.
      10'b1010010000,  // G --.
      10'b0101010100,  // H ....
      10'b0101000000,  // I ..
      10'b0110101000,  // J .---
      10'b1001100000,  // K -.-
      10'b0110010100,  // L .-..
      10'b1010000000,  // M --
      10'b1001000000,  // N -.
      10'b1010100000,  // O ---
      10'b0110100100,  // P .--.
      10'b1010011000,  // Q --.-
      10'b0110010000,  // R .-.
      10'b0101010000,  // S ...
      10'b1000000000,  // T -
      10'b0101100000,  // U ..-
      10'b0101011000,  // V ...-
      10'b0110100000,  // W .--
      10'b1001011000,  // X -..-
      10'b1001101000,  // Y -.--
      10'b1010010100,  // Z --..
      10'b1010101010,  // 0 -----
      10'b0110101010,  // 1 .----
      10'b0101101010,  // 2 ..---
      10'b0101011010,  // 3 ...--
      10'b0101010110,  // 4 ....-
      10'b0101010101,  // 5 .....
      10'b1001010101,  // 6 -....
      10'b1010010101,  // 7 --...
      10'b1010100101,  // 8 ---..
      10'b1010101001   // 9 ----.
   };

   function automatic logic [7:0] morse_ascii(input int idx);
      if (idx < 26) begin
         return 8'h41 + 8'(idx);
      end
      return 8'h30 + 8'(idx - 26);
   endfunction

endpackage

// File: rtl/morse_sequence_decoder_if.sv
// ----------------------------------------------------------------------------
// morse_sequence_decoder_if
//  Groups the producer-facing inputs and the consumer-facing FIFO/status
//  outputs of the Morse decoder.
//   outputbits, spa_end, sent : symbol group, separator kind, publish strobe
//   rd_en                     : pop request from the display/UART stage
//   char_out, char_valid      : FIFO head and non-empty flag
//   count                     : entries held
//   msg_done, bad_symbol, overflow : status flags
//  slave  = decoder side, master = producer/consumer side.
// ----------------------------------------------------------------------------
interface morse_sequence_decoder_if #(
   parameter int DEPTH  = 16,
   parameter int CHAR_W = 8
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [9:0]        outputbits;
   logic              spa_end;
   logic              sent;
   logic              rd_en;
   logic [CHAR_W-1:0] char_out;
   logic              char_valid;
   logic [CNT_W-1:0]  count;
   logic              msg_done;
   logic              bad_symbol;
   logic              overflow;

   modport slave (
      input  outputbits, spa_end, sent, rd_en,
      output char_out, char_valid, count, msg_done, bad_symbol, overflow
   );

   modport master (
      output outputbits, spa_end, sent, rd_en,
      input  char_out, char_valid, count, msg_done, bad_symbol, overflow
   );
endinterface

// File: rtl/morse_symbol_lut.sv
// ----------------------------------------------------------------------------
// morse_symbol_lut
//  Combinational decode of a 10-bit symbol group to a character.
//   pat_i   in  10      symbol group
//   valid_o out 1       pattern is one of A-Z / 0-9
//   char_o  out CHAR_W  decoded character, INVALID_CHAR when not valid
//  Any pattern outside the table (11 slots, gaps, unassigned sequences,
//  all-none) reports valid_o = 0.
// ----------------------------------------------------------------------------
module morse_symbol_lut
   import morse_pkg::*;
#(
   parameter int                CHAR_W       = 8,
   parameter logic [CHAR_W-1:0] INVALID_CHAR = CHAR_W'(INVALID_CHAR_DEFAULT)
) (
   input  logic [9:0]        pat_i,
   output logic              valid_o,
   output logic [CHAR_W-1:0] char_o
);

   always_comb begin
      valid_o = 1'b0;
      char_o  = INVALID_CHAR;
      for (int i = 0; i < NUM_CODES; i++) begin
         if (pat_i == MORSE_PAT[i]) begin
            valid_o = 1'b1;
            char_o  = CHAR_W'(morse_ascii(i));
         end
      end
   end

endmodule

// File: rtl/morse_sequence_decoder.sv
// ----------------------------------------------------------------------------
// morse_sequence_decoder
//  Captures symbol groups published by the Morse producer, decodes them to
//  ASCII and buffers the characters in a first-word-fall-through FIFO.
//   clk    in  1   system clock
//   Reset  in  1   asynchronous reset, active low
//   Clear  in  1   synchronous flush, active high
//   bus    slave modport of morse_sequence_decoder_if (symbol input, FIFO
//          head/pop, count and status flags)
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  IDLE    | waiting for a sent rising edge
//  LOOKUP  | latched pattern is being decoded; LUT result registered
//  PUSH    | character pushed (or dropped when full); flags updated
//  DONE    | end of message seen; sent ignored until Clear/Reset
// ----------------------------------------------------------------------------
module morse_sequence_decoder
   import morse_pkg::*;
#(
   parameter int                DEPTH        = 16,
   parameter int                CHAR_W       = 8,
   parameter logic [CHAR_W-1:0] INVALID_CHAR = CHAR_W'(INVALID_CHAR_DEFAULT)
) (
   input  logic                     clk,
   input  logic                     Reset,
   input  logic                     Clear,
   morse_sequence_decoder_if.slave  bus
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   state_e            state_q, state_d;
   logic              sent_q;
   logic [9:0]        pat_q, pat_d;
   logic              end_q, end_d;
   logic [CHAR_W-1:0] char_q, char_d;
   logic              ok_q, ok_d;
   logic              bad_q, bad_d;
   logic              ovf_q, ovf_d;
   logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CHAR_W-1:0] mem_q [DEPTH];

   logic              lut_ok;
   logic [CHAR_W-1:0] lut_char;
   logic              sent_rise;
   logic [CNT_W-1:0]  count;
   logic              empty;
   logic              full;
   logic              do_pop;
   logic              do_push;

   morse_symbol_lut #(
      .CHAR_W       (CHAR_W),
      .INVALID_CHAR (INVALID_CHAR)
   ) u_lut (
      .pat_i   (pat_q),
      .valid_o (lut_ok),
      .char_o  (lut_char)
   );

   assign sent_rise = bus.sent & ~sent_q;
   assign count     = wr_ptr_q - rd_ptr_q;
   assign empty     = (count == '0);
   assign full      = (count == CNT_W'(DEPTH));
   assign do_pop    = bus.rd_en & ~empty & ~Clear;

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      end_d   = end_q;
      char_d  = char_q;
      ok_d    = ok_q;
      bad_d   = bad_q;
      ovf_d   = ovf_q;
      do_push = 1'b0;
      if (Clear) begin
         state_d = ST_IDLE;
         bad_d   = 1'b0;
         ovf_d   = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (sent_rise) begin
                  pat_d   = bus.outputbits;
                  end_d   = bus.spa_end;
                  state_d = ST_LOOKUP;
               end
            end
            ST_LOOKUP: begin
               char_d  = lut_char;
               ok_d    = lut_ok;
               state_d = ST_PUSH;
            end
            ST_PUSH: begin
               // An all-none group is a bare separator: nothing to store.
               if (pat_q != '0) begin
                  if (!ok_q) begin
                     bad_d = 1'b1;
                  end
                  // A simultaneous pop frees the slot, so a full FIFO still accepts.
                  if (!full || do_pop) begin
                     do_push = 1'b1;
                  end else begin
                     ovf_d = 1'b1;
                  end
               end
               state_d = end_q ? ST_DONE : ST_IDLE;
            end
            ST_DONE: begin
               state_d = ST_DONE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q + CNT_W'(do_push);
      rd_ptr_d = rd_ptr_q + CNT_W'(do_pop);
      if (Clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end
   end

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         state_q  <= ST_IDLE;
         sent_q   <= 1'b0;
         pat_q    <= '0;
         end_q    <= 1'b0;
         char_q   <= '0;
         ok_q     <= 1'b0;
         bad_q    <= 1'b0;
         ovf_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         sent_q   <= bus.sent;
         pat_q    <= pat_d;
         end_q    <= end_d;
         char_q   <= char_d;
         ok_q     <= ok_d;
         bad_q    <= bad_d;
         ovf_q    <= ovf_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset; the head is masked while empty.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= char_q;
      end
   end

   assign bus.char_out   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   assign bus.char_valid = ~empty;
   assign bus.count      = count;
   assign bus.msg_done   = (state_q == ST_DONE);
   assign bus.bad_symbol = bad_q;
   assign bus.overflow   = ovf_q;

endmodule
